// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save adder slice.
package csa_pkg;

    // Default operand width used when no N is supplied.
    localparam int unsigned CSA_DEFAULT_W = 4;

    // Majority of three bits; the carry output of a 3:2 compressor cell.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/carry_save_adder_if.sv
// Operand/result bundle between a producer stage and the carry-save adder.
interface carry_save_adder_if
    import csa_pkg::*;
#(
    parameter int unsigned N = CSA_DEFAULT_W
) ();

    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic         out_valid;
    logic [N-1:0] sum;
    logic [N-1:0] carry;
    logic [N+1:0] total;

    // Producer side: drives operands, observes results.
    modport master (
        output in_valid, a, b, c,
        input  out_valid, sum, carry, total
    );

    // Adder side: consumes operands, drives results.
    modport slave (
        input  in_valid, a, b, c,
        output out_valid, sum, carry, total
    );

endinterface

// File: rtl/csa_full_adder.sv
// 1-bit 3:2 cell: sum bit and majority carry of three equal-weight inputs.
module csa_full_adder
    import csa_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic co
);

    // Pure combinational cell; no state here.
    always_comb begin
        s  = x ^ y ^ z;
        co = maj3(x, y, z);
    end

endmodule

// File: rtl/carry_save_adder.sv
// Registered 3:2 carry-save adder with a ripple-resolved total.
module carry_save_adder
    import csa_pkg::*;
#(
    parameter int unsigned N = CSA_DEFAULT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    carry_save_adder_if.slave  bus
);

    logic [N-1:0] sum_d;
    logic [N-1:0] carry_d;
    logic [N-1:0] sum_q;
    logic [N-1:0] carry_q;
    logic         valid_q;

    // Compressor stage: N independent cells, no inter-bit ripple.
    for (genvar i = 0; i < N; i++) begin : g_compress
        csa_full_adder u_cell (
            .x  (bus.a[i]),
            .y  (bus.b[i]),
            .z  (bus.c[i]),
            .s  (sum_d[i]),
            .co (carry_d[i])
        );
    end

    // Capture on valid, hold otherwise; reset clears any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end
    end

    // Resolution adder operands: carry carries weight 2^(i+1), hence the shift.
    logic [N+1:0] op_s;
    logic [N+1:0] op_c;
    logic [N+1:0] total_w;
    logic [N+2:0] rc;
    logic         rc_unused;

    // Zero-extend and align the redundant pair for the ripple chain.
    always_comb begin
        op_s  = {2'b00, sum_q};
        op_c  = {1'b0, carry_q, 1'b0};
        rc[0] = 1'b0;
    end

    // Ripple chain built from the same cells, z acting as carry-in.
    for (genvar i = 0; i < N + 2; i++) begin : g_resolve
        csa_full_adder u_rca (
            .x  (op_s[i]),
            .y  (op_c[i]),
            .z  (rc[i]),
            .s  (total_w[i]),
            .co (rc[i+1])
        );
    end

    // The top carry-out is always zero since 3*(2^N-1) fits in N+2 bits.
    assign rc_unused = rc[N+2];

    // Drive the result side of the bus from the registers.
    always_comb begin
        bus.out_valid = valid_q;
        bus.sum       = sum_q;
        bus.carry     = carry_q;
        bus.total     = total_w;
    end

endmodule

// File: tb/tb_carry_save_adder.sv
// Directed and exhaustive checks of carry_save_adder at N=4, plus random N=1/N=16.
module tb_carry_save_adder;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    carry_save_adder_if #(.N(4))  bus4  ();
    carry_save_adder_if #(.N(1))  bus1  ();
    carry_save_adder_if #(.N(16)) bus16 ();

    carry_save_adder #(.N(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    carry_save_adder #(.N(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    carry_save_adder #(.N(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect4(input string tag, input logic [3:0] es, input logic [3:0] ec,
                           input logic [5:0] et, input logic ev);
        check({tag, " sum"},   32'(bus4.sum),       32'(es));
        check({tag, " carry"}, 32'(bus4.carry),     32'(ec));
        check({tag, " total"}, 32'(bus4.total),     32'(et));
        check({tag, " valid"}, 32'(bus4.out_valid), 32'(ev));
    endtask

    task automatic drive4(input logic v, input logic [3:0] va, input logic [3:0] vb,
                          input logic [3:0] vc);
        @(negedge clk);
        bus4.in_valid = v;
        bus4.a        = va;
        bus4.b        = vb;
        bus4.c        = vc;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  x4, y4, z4;
        logic        x1, y1, z1;
        logic [15:0] x16, y16, z16;
        int          e;

        n_checks = 0;
        n_pass   = 0;

        // Reset held while valid garbage is presented.
        rst_n = 1'b0;
        bus4.in_valid  = 1'b1; bus4.a  = 4'hA;     bus4.b  = 4'h7;     bus4.c  = 4'hD;
        bus1.in_valid  = 1'b1; bus1.a  = 1'b1;     bus1.b  = 1'b1;     bus1.c  = 1'b1;
        bus16.in_valid = 1'b1; bus16.a = 16'hBEEF; bus16.b = 16'h1234; bus16.c = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        expect4("reset", 4'h0, 4'h0, 6'd0, 1'b0);
        check("reset n16 total", 32'(bus16.total), 32'd0);
        check("reset n1 valid", 32'(bus1.out_valid), 32'd0);

        // Release with the first real vector.
        drive4(1'b1, 4'b0011, 4'b0101, 4'b0110);
        rst_n = 1'b1;
        bus1.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        edge_wait();
        expect4("first", 4'b0000, 4'b0111, 6'd14, 1'b1);

        drive4(1'b1, 4'b1111, 4'b0001, 4'b0001);
        edge_wait();
        expect4("f11", 4'b1111, 4'b0001, 6'd17, 1'b1);

        drive4(1'b1, 4'b1001, 4'b1001, 4'b1001);
        edge_wait();
        expect4("999", 4'b1001, 4'b1001, 6'd27, 1'b1);

        drive4(1'b1, 4'b1111, 4'b1111, 4'b1111);
        edge_wait();
        expect4("max", 4'b1111, 4'b1111, 6'd45, 1'b1);

        drive4(1'b1, 4'b0000, 4'b0000, 4'b0000);
        edge_wait();
        expect4("zero", 4'b0000, 4'b0000, 6'd0, 1'b1);

        // Back-to-back: each result must not appear before its edge.
        drive4(1'b1, 4'h2, 4'h3, 4'h4);
        #1 check("b2b0 early sum", 32'(bus4.sum), 32'h0);
        edge_wait();
        expect4("b2b0", 4'b0101, 4'b0010, 6'd9, 1'b1);

        drive4(1'b1, 4'h7, 4'h1, 4'h8);
        #1 check("b2b1 early sum", 32'(bus4.sum), 32'h5);
        edge_wait();
        expect4("b2b1", 4'b1110, 4'b0001, 6'd16, 1'b1);

        drive4(1'b1, 4'hC, 4'hA, 4'h6);
        #1 check("b2b2 early sum", 32'(bus4.sum), 32'hE);
        edge_wait();
        expect4("b2b2", 4'b0000, 4'b1110, 6'd28, 1'b1);

        // Hold: invalid inputs must not disturb the registered pair.
        drive4(1'b0, 4'h5, 4'hA, 4'h3);
        edge_wait();
        expect4("hold0", 4'b0000, 4'b1110, 6'd28, 1'b0);
        drive4(1'b0, 4'hF, 4'hF, 4'hF);
        edge_wait();
        expect4("hold1", 4'b0000, 4'b1110, 6'd28, 1'b0);

        // Asynchronous reset mid-stream, checked well before the next edge.
        drive4(1'b1, 4'hF, 4'hF, 4'hF);
        edge_wait();
        expect4("pre rst", 4'hF, 4'hF, 6'd45, 1'b1);
        rst_n = 1'b0;
        #1;
        expect4("async rst", 4'h0, 4'h0, 6'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus4.in_valid = 1'b0;

        // Exhaustive N=4 sweep, with random N=1 and N=16 vectors alongside.
        for (int i = 0; i < 4096; i++) begin
            x4 = i[3:0];
            y4 = i[7:4];
            z4 = i[11:8];
            x1 = 1'($urandom_range(0, 1));
            y1 = 1'($urandom_range(0, 1));
            z1 = 1'($urandom_range(0, 1));
            x16 = 16'($urandom);
            y16 = 16'($urandom);
            z16 = 16'($urandom);
            @(negedge clk);
            bus4.in_valid = 1'b1; bus4.a = x4; bus4.b = y4; bus4.c = z4;
            bus1.in_valid  = (i < 1000); bus1.a  = x1;  bus1.b  = y1;  bus1.c  = z1;
            bus16.in_valid = (i < 1000); bus16.a = x16; bus16.b = y16; bus16.c = z16;
            edge_wait();
            e = int'(x4) + int'(y4) + int'(z4);
            check("sweep4 sum",   32'(bus4.sum),   32'(x4 ^ y4 ^ z4));
            check("sweep4 carry", 32'(bus4.carry), 32'((x4 & y4) | (x4 & z4) | (y4 & z4)));
            check("sweep4 total", 32'(bus4.total), 32'(e));
            if (i < 1000) begin
                e = int'(x1) + int'(y1) + int'(z1);
                check("rnd1 sum",   32'(bus1.sum),   32'(x1 ^ y1 ^ z1));
                check("rnd1 carry", 32'(bus1.carry), 32'((x1 & y1) | (x1 & z1) | (y1 & z1)));
                check("rnd1 total", 32'(bus1.total), 32'(e));
                e = int'(x16) + int'(y16) + int'(z16);
                check("rnd16 sum",   32'(bus16.sum),   32'(x16 ^ y16 ^ z16));
                check("rnd16 carry", 32'(bus16.carry),
                      32'((x16 & y16) | (x16 & z16) | (y16 & z16)));
                check("rnd16 total", 32'(bus16.total), 32'(e));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
